// File: rtl/dff_pkg.sv
// Shared constants and data type for the dff_pipe register family and its
// verification interface bundle.
package dff_pkg;

  localparam int DFF_WIDTH_DEF  = 1;
  localparam int DFF_STAGES_DEF = 1;

  typedef logic [DFF_WIDTH_DEF-1:0] data_t;

endpackage : dff_pkg

// File: rtl/dff_if.sv
// Interface bundle through which a test drives d and samples q of a dff_pipe.
// clk and reset come from the enclosing top level.
interface dff_if
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH_DEF
) (
  input logic clk,
  input logic reset
);

  typedef logic [WIDTH-1:0] data_t;

  data_t d;
  data_t q;

  modport tb  (input clk, input reset, input q, output d);
  modport dut (input clk, input reset, input d, output q);

endinterface : dff_if

// File: rtl/dff_stage.sv
// One WIDTH-bit register stage with asynchronous active-low reset to RESET_VAL.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignment so every stage samples
  // its neighbour's pre-edge value and the chain shifts by exactly one step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule : dff_stage

// File: rtl/dff_pipe.sv
// Parameterised D flip-flop pipeline: q is d delayed by STAGES rising edges.
// Default configuration is a single-bit DFF.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH_DEF,
  parameter int               STAGES    = DFF_STAGES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $fatal(1, "dff_pipe: WIDTH and STAGES must both be >= 1");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    // Stage 0 captures the input; later stages capture their predecessor.
    if (i == 0) begin : g_head
      assign stage_d = d;
    end else begin : g_body
      assign stage_d = stage_q[i-1];
    end

    dff_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .d    (stage_d),
      .q    (stage_q[i])
    );
  end

  assign q = stage_q[STAGES-1];

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: three configurations share clk and reset; a
// reference model of captured history predicts q, a monitor compares each edge.
module tb_dff_pipe;
  import dff_pkg::*;

  logic clk;
  logic reset;

  dff_if #(.WIDTH(1)) if_a (.clk(clk), .reset(reset));
  dff_if #(.WIDTH(8)) if_b (.clk(clk), .reset(reset));
  dff_if #(.WIDTH(4)) if_c (.clk(clk), .reset(reset));

  dff_pipe u_dut_a (
    .clk  (clk),
    .reset(reset),
    .d    (if_a.d),
    .q    (if_a.q)
  );

  dff_pipe #(.WIDTH(8), .STAGES(3)) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .d    (if_b.d),
    .q    (if_b.q)
  );

  dff_pipe #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hC)) u_dut_c (
    .clk  (clk),
    .reset(reset),
    .d    (if_c.d),
    .q    (if_c.q)
  );

  typedef struct {
    logic       a;
    logic [7:0] b;
    logic [3:0] c;
  } exp_t;

  exp_t       exp_q [$];
  logic       hist_a [$];
  logic [7:0] hist_b [$];
  logic [3:0] hist_c [$];

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: q shows the value captured STAGES captures ago, or the reset value
  // while fewer captures than STAGES have happened since reset.
  task automatic drive(input logic r, input logic da, input logic [7:0] db, input logic [3:0] dc);
    exp_t e;
    reset  = r;
    if_a.d = da;
    if_b.d = db;
    if_c.d = dc;
    if (!r) begin
      hist_a.delete();
      hist_b.delete();
      hist_c.delete();
    end else begin
      hist_a.push_back(da);
      hist_b.push_back(db);
      hist_c.push_back(dc);
    end
    e.a = (hist_a.size() >= 1) ? hist_a[hist_a.size()-1] : 1'b0;
    e.b = (hist_b.size() >= 3) ? hist_b[hist_b.size()-3] : 8'h00;
    e.c = (hist_c.size() >= 2) ? hist_c[hist_c.size()-2] : 4'hC;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic da, input logic [7:0] db, input logic [3:0] dc);
    @(negedge clk);
    drive(r, da, db, dc);
  endtask

  task automatic step_rand(input logic r);
    step(r, 1'($urandom), 8'($urandom), 4'($urandom));
  endtask

  // Monitor: one expected entry per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 8'd1, 8'd0);
      end else begin
        e = exp_q.pop_front();
        check("q_a", {7'd0, if_a.q}, {7'd0, e.a});
        check("q_b", if_b.q, e.b);
        check("q_c", {4'd0, if_c.q}, {4'd0, e.c});
      end
    end
  end

  initial begin
    reset  = 1'b1;
    if_a.d = 1'b0;
    if_b.d = 8'h00;
    if_c.d = 4'h0;
    #1;
    drive(1'b0, 1'b1, 8'hFF, 4'hF);
    #1;
    check("reset_a", {7'd0, if_a.q}, 8'h00);
    check("reset_b", if_b.q, 8'h00);
    check("reset_c", {4'd0, if_c.q}, 8'h0C);

    for (int i = 0; i < 3; i++) step(1'b0, 1'(i), 8'(8'h5A ^ i), 4'(i + 1));

    // Follow on the single-bit DFF, then hold C at 3 to see its release value.
    step(1'b1, 1'b1, 8'h00, 4'h3);
    step(1'b1, 1'b0, 8'h00, 4'h3);
    step(1'b1, 1'b1, 8'h00, 4'h3);

    // Async assertion two time units after an edge, no clock edge needed.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_a", {7'd0, if_a.q}, 8'h00);
    check("async_b", if_b.q, 8'h00);
    check("async_c", {4'd0, if_c.q}, 8'h0C);
    for (int i = 0; i < 3; i++) step_rand(1'b0);

    // Single 0xA5 pulse through the 3-stage pipe.
    step(1'b1, 1'b1, 8'hA5, 4'h3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 4'h3);

    // Random soak with occasional reset pulses.
    for (int i = 0; i < 110; i++) step_rand(($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dff_pipe
